// File: rtl/jk_pkg.sv
// Shared types and the JK excitation rules for the target-driven JK register bank.
package jk_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      DRIVE = 2'd2,
      CHECK = 2'd3
   } jk_state_t;

   typedef struct packed {
      logic j;
      logic k;
   } jk_pair_t;

   // Minimal excitation: set only 0->1 bits, reset only 1->0 bits, don't-cares forced to 0.
   function automatic jk_pair_t jk_excite(input logic q, input logic tgt);
      jk_pair_t p;
      p.j = ~q & tgt;
      p.k = q & ~tgt;
      return p;
   endfunction

   function automatic logic jk_next(input logic j, input logic k, input logic q);
      return (j & ~q) | (~k & q);
   endfunction

endpackage

// File: rtl/jk_tgt_fifo.sv
// Target queue: power-of-two circular buffer with registered occupancy count.
module jk_tgt_fifo #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           pop_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             push_ok, pop_ok;

   assign full     = (count_q == CW'(DEPTH));
   assign empty    = (count_q == '0);
   assign count    = count_q;
   assign pop_data = mem_q[rd_ptr_q];
   assign push_ok  = push & ~full;
   assign pop_ok   = pop & ~empty;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // NOTE: flops use non-blocking assignments so all state updates see pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage is deliberately not reset; count and pointers alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/jk_excite_seq.sv
// Queued-target JK sequencer: pops a target, drives J/K excitation for one cycle, then verifies the bank.
module jk_excite_seq
   import jk_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       tgt_valid,
   input  logic [WIDTH-1:0]           tgt_data,
   output logic                       tgt_ready,
   output logic [WIDTH-1:0]           j_out,
   output logic [WIDTH-1:0]           k_out,
   output logic                       step_valid,
   output logic [WIDTH-1:0]           q_out,
   output logic                       done,
   output logic                       err,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int CW = $clog2(DEPTH+1);

   jk_state_t        state_q, state_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] tgt_q, tgt_d;
   logic [WIDTH-1:0] j_q, j_d;
   logic [WIDTH-1:0] k_q, k_d;
   logic             step_q, step_d;
   logic             done_q, done_d;
   logic             err_q, err_d;

   logic             fifo_pop, fifo_full, fifo_empty;
   logic [WIDTH-1:0] fifo_head;
   logic [CW-1:0]    fifo_count;
   jk_pair_t         pair;

   jk_tgt_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (tgt_valid),
      .push_data (tgt_data),
      .pop       (fifo_pop),
      .pop_data  (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // Ready follows the registered count, so a same-cycle pop never opens a slot early.
   assign tgt_ready  = ~fifo_full;
   assign count      = fifo_count;
   assign j_out      = j_q;
   assign k_out      = k_q;
   assign step_valid = step_q;
   assign q_out      = q_q;
   assign done       = done_q;
   assign err        = err_q;

   always_comb begin
      state_d  = state_q;
      q_d      = q_q;
      tgt_d    = tgt_q;
      j_d      = '0;
      k_d      = '0;
      step_d   = 1'b0;
      done_d   = 1'b0;
      err_d    = err_q;
      fifo_pop = 1'b0;
      pair     = '0;
      case (state_q)
         IDLE: begin
            if (fifo_count != '0) state_d = LOAD;
         end
         LOAD: begin
            fifo_pop = ~fifo_empty;
            tgt_d    = fifo_head;
            step_d   = 1'b1;
            for (int i = 0; i < WIDTH; i++) begin
               pair   = jk_excite(q_q[i], fifo_head[i]);
               j_d[i] = pair.j;
               k_d[i] = pair.k;
            end
            state_d = DRIVE;
         end
         DRIVE: begin
            for (int i = 0; i < WIDTH; i++) begin
               q_d[i] = jk_next(j_q[i], k_q[i], q_q[i]);
            end
            done_d  = 1'b1;
            if (q_d != tgt_q) err_d = 1'b1;
            state_d = CHECK;
         end
         CHECK: begin
            state_d = (fifo_count != '0) ? LOAD : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         q_q     <= '0;
         tgt_q   <= '0;
         j_q     <= '0;
         k_q     <= '0;
         step_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         tgt_q   <= tgt_d;
         j_q     <= j_d;
         k_q     <= k_d;
         step_q  <= step_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_jk_excite_seq.sv
// Self-checking bench for jk_excite_seq: directed scenarios plus a randomized run against a queue model.
module tb_jk_excite_seq;

   localparam int W  = 4;
   localparam int D  = 4;
   localparam int CW = $clog2(D+1);

   logic          clk = 1'b0;
   logic          rst;
   logic          tgt_valid;
   logic [W-1:0]  tgt_data;
   logic          tgt_ready;
   logic [W-1:0]  j_out, k_out, q_out;
   logic          step_valid, done, err;
   logic [CW-1:0] count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   jk_excite_seq #(.WIDTH(W), .DEPTH(D)) dut (
      .clk        (clk),
      .rst        (rst),
      .tgt_valid  (tgt_valid),
      .tgt_data   (tgt_data),
      .tgt_ready  (tgt_ready),
      .j_out      (j_out),
      .k_out      (k_out),
      .step_valid (step_valid),
      .q_out      (q_out),
      .done       (done),
      .err        (err),
      .count      (count)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      tgt_valid = 1'b0;
      tgt_data  = '0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      tgt_valid = 1'b1;
      tgt_data  = 4'hF;
      tick();
      tick();
      checks++;
      if ({q_out, j_out, k_out, step_valid, done, err, count} !== '0) begin
         errors++;
         $display("FAIL reset_state: got q=%b j=%b k=%b sv=%b done=%b err=%b count=%0d, expected all zero",
                  q_out, j_out, k_out, step_valid, done, err, count);
      end
      rst       = 1'b0;
      tgt_valid = 1'b0;
      checks++;
      if (tgt_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready: got %b expected 1", tgt_ready);
      end
   endtask

   task automatic test_single_step();
      do_reset();
      tgt_valid = 1'b1;
      tgt_data  = 4'b1010;
      tick();
      tgt_valid = 1'b0;
      checks++;
      if (count !== 3'd1 || step_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_queued: got count=%0d sv=%b expected count=1 sv=0", count, step_valid);
      end
      tick();
      checks++;
      if (step_valid !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL single_load: got sv=%b done=%b expected 0 0", step_valid, done);
      end
      tick();
      checks++;
      if (step_valid !== 1'b1 || j_out !== 4'b1010 || k_out !== 4'b0000) begin
         errors++;
         $display("FAIL single_drive: got sv=%b j=%b k=%b expected 1 1010 0000", step_valid, j_out, k_out);
      end
      tick();
      checks++;
      if (done !== 1'b1 || q_out !== 4'b1010 || step_valid !== 1'b0 || err !== 1'b0) begin
         errors++;
         $display("FAIL single_check: got done=%b q=%b sv=%b err=%b expected 1 1010 0 0", done, q_out, step_valid, err);
      end
      tick();
      checks++;
      if (done !== 1'b0 || q_out !== 4'b1010) begin
         errors++;
         $display("FAIL single_done_pulse: got done=%b q=%b expected 0 1010", done, q_out);
      end
   endtask

   task automatic test_toggle();
      tgt_valid = 1'b1;
      tgt_data  = 4'b0101;
      tick();
      tgt_valid = 1'b0;
      tick();
      tick();
      checks++;
      if (step_valid !== 1'b1 || j_out !== 4'b0101 || k_out !== 4'b1010) begin
         errors++;
         $display("FAIL toggle_drive: got sv=%b j=%b k=%b expected 1 0101 1010", step_valid, j_out, k_out);
      end
      tick();
      checks++;
      if (done !== 1'b1 || q_out !== 4'b0101 || err !== 1'b0) begin
         errors++;
         $display("FAIL toggle_check: got done=%b q=%b err=%b expected 1 0101 0", done, q_out, err);
      end
      tick();
   endtask

   task automatic test_same_value();
      tgt_valid = 1'b1;
      tgt_data  = 4'b0101;
      tick();
      tgt_valid = 1'b0;
      tick();
      tick();
      checks++;
      if (step_valid !== 1'b1 || j_out !== 4'b0000 || k_out !== 4'b0000) begin
         errors++;
         $display("FAIL same_drive: got sv=%b j=%b k=%b expected 1 0000 0000", step_valid, j_out, k_out);
      end
      tick();
      checks++;
      if (done !== 1'b1 || q_out !== 4'b0101 || err !== 1'b0) begin
         errors++;
         $display("FAIL same_check: got done=%b q=%b err=%b expected 1 0101 0", done, q_out, err);
      end
      tick();
   endtask

   // Six distinct targets offered back to back: four fill the queue, later ones wait for a pop.
   task automatic test_full_queue();
      logic [W-1:0] vals [6];
      logic [W-1:0] exp_q [$];
      logic [W-1:0] model_q;
      int  idx, cyc, last_done, fifo_cnt;
      bit  saw_block;
      vals = '{4'h3, 4'hC, 4'h6, 4'h9, 4'hF, 4'h1};
      do_reset();
      model_q   = '0;
      idx       = 0;
      cyc       = 0;
      last_done = -1;
      saw_block = 1'b0;
      while ((idx < 6 || exp_q.size() != 0) && cyc < 200) begin
         if (done === 1'b1) begin
            checks++;
            if (exp_q.size() == 0 || q_out !== exp_q[0]) begin
               errors++;
               $display("FAIL full_order: got q=%h expected %h", q_out, (exp_q.size() != 0) ? exp_q[0] : 4'hx);
            end
            if (exp_q.size() != 0) begin
               model_q = exp_q.pop_front();
            end
            if (last_done >= 0) begin
               checks++;
               if (cyc - last_done != 3) begin
                  errors++;
                  $display("FAIL full_spacing: got %0d cycles between done pulses expected 3", cyc - last_done);
               end
            end
            last_done = cyc;
         end
         fifo_cnt = exp_q.size() - ((step_valid === 1'b1) ? 1 : 0);
         checks++;
         if (count !== CW'(fifo_cnt) || tgt_ready !== (fifo_cnt != D)) begin
            errors++;
            $display("FAIL full_count: got count=%0d ready=%b expected count=%0d ready=%b",
                     count, tgt_ready, fifo_cnt, (fifo_cnt != D));
         end
         tgt_valid = (idx < 6);
         tgt_data  = (idx < 6) ? vals[idx] : '0;
         if (tgt_valid && !tgt_ready) saw_block = 1'b1;
         if (tgt_valid && tgt_ready) begin
            exp_q.push_back(vals[idx]);
            idx++;
         end
         tick();
         cyc++;
      end
      tgt_valid = 1'b0;
      checks++;
      if (idx != 6 || exp_q.size() != 0 || !saw_block || model_q !== 4'h1 || err !== 1'b0) begin
         errors++;
         $display("FAIL full_complete: got accepted=%0d pending=%0d blocked=%b last=%h err=%b expected 6 0 1 1 0",
                  idx, exp_q.size(), saw_block, model_q, err);
      end
   endtask

   task automatic test_reset_in_drive();
      bit saw_done;
      do_reset();
      tgt_valid = 1'b1;
      tgt_data  = 4'hA;
      tick();
      tgt_data  = 4'h5;
      tick();
      tgt_data  = 4'h7;
      tick();
      tgt_valid = 1'b0;
      checks++;
      if (step_valid !== 1'b1 || count !== 3'd2) begin
         errors++;
         $display("FAIL rst_drive_setup: got sv=%b count=%0d expected 1 2", step_valid, count);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (q_out !== '0 || count !== '0 || tgt_ready !== 1'b1 || step_valid !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL rst_drive_after: got q=%b count=%0d ready=%b sv=%b done=%b expected 0 0 1 0 0",
                  q_out, count, tgt_ready, step_valid, done);
      end
      saw_done = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (done === 1'b1 || step_valid === 1'b1) saw_done = 1'b1;
      end
      checks++;
      if (saw_done || count !== '0) begin
         errors++;
         $display("FAIL rst_drive_quiet: got activity=%b count=%0d expected 0 0", saw_done, count);
      end
   endtask

   task automatic test_random();
      logic [W-1:0] exp_q [$];
      logic [W-1:0] model_q;
      int pushed, cyc, last_done, fifo_cnt;
      do_reset();
      model_q   = '0;
      pushed    = 0;
      cyc       = 0;
      last_done = -10;
      while ((pushed < 1000 || exp_q.size() != 0) && cyc < 20000) begin
         if (done === 1'b1) begin
            checks++;
            if (exp_q.size() == 0 || q_out !== exp_q[0] || err !== 1'b0) begin
               errors++;
               $display("FAIL rand_done: cycle %0d got q=%h err=%b expected q=%h err=0",
                        cyc, q_out, err, (exp_q.size() != 0) ? exp_q[0] : 4'hx);
            end
            if (exp_q.size() != 0) model_q = exp_q.pop_front();
            checks++;
            if (cyc - last_done < 3) begin
               errors++;
               $display("FAIL rand_spacing: got %0d cycles between done pulses expected at least 3", cyc - last_done);
            end
            last_done = cyc;
         end
         if (step_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0 || j_out !== (~model_q & exp_q[0]) || k_out !== (model_q & ~exp_q[0])) begin
               errors++;
               $display("FAIL rand_excite: cycle %0d got j=%b k=%b from q=%b", cyc, j_out, k_out, model_q);
            end
         end else if (j_out !== '0 || k_out !== '0) begin
            checks++;
            errors++;
            $display("FAIL rand_idle_jk: cycle %0d got j=%b k=%b expected 0 0", cyc, j_out, k_out);
         end
         fifo_cnt = exp_q.size() - ((step_valid === 1'b1) ? 1 : 0);
         checks++;
         if (count !== CW'(fifo_cnt) || tgt_ready !== (fifo_cnt != D)) begin
            errors++;
            $display("FAIL rand_count: cycle %0d got count=%0d ready=%b expected count=%0d ready=%b",
                     cyc, count, tgt_ready, fifo_cnt, (fifo_cnt != D));
         end
         tgt_valid = (pushed < 1000) && ($urandom_range(0, 99) < 60);
         tgt_data  = W'($urandom);
         if (tgt_valid && tgt_ready) begin
            exp_q.push_back(tgt_data);
            pushed++;
         end
         tick();
         cyc++;
      end
      tgt_valid = 1'b0;
      checks++;
      if (pushed != 1000 || exp_q.size() != 0 || err !== 1'b0) begin
         errors++;
         $display("FAIL rand_complete: got pushed=%0d pending=%0d err=%b expected 1000 0 0", pushed, exp_q.size(), err);
      end
   endtask

   initial begin
      rst       = 1'b1;
      tgt_valid = 1'b0;
      tgt_data  = '0;
      test_reset();
      test_single_step();
      test_toggle();
      test_same_value();
      test_full_queue();
      test_reset_in_drive();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
